// File: rtl/bp_burst_stream_arbiter.sv
// Round-robin arbiter merging several BedRock burst streams (header + data) onto one client port.
// The grant is held from header acceptance until the last data beat of that message.
module bp_burst_stream_arbiter #(
  parameter int unsigned paddr_width_p     = 40,
  parameter int unsigned cce_block_width_p = 512,
  parameter int unsigned data_width_p      = 64,
  parameter int unsigned payload_width_p   = 16,
  parameter int unsigned num_req_p         = 2,
  parameter logic [15:0] payload_mask_p    = '0,
  localparam int unsigned hdr_w_lp = payload_width_p + 3 + paddr_width_p + 8,
  localparam int unsigned gid_w_lp = $clog2(num_req_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p*hdr_w_lp-1:0]     msg_header_i,
  input  logic [num_req_p-1:0]              msg_header_v_i,
  output logic [num_req_p-1:0]              msg_header_ready_and_o,
  input  logic [num_req_p*data_width_p-1:0] msg_data_i,
  input  logic [num_req_p-1:0]              msg_data_v_i,
  output logic [num_req_p-1:0]              msg_data_ready_and_o,
  output logic [hdr_w_lp-1:0]               msg_header_o,
  output logic                              msg_header_v_o,
  input  logic                              msg_header_ready_and_i,
  output logic [data_width_p-1:0]           msg_data_o,
  output logic                              msg_data_v_o,
  input  logic                              msg_data_ready_and_i,
  output logic [gid_w_lp-1:0]               grant_id_o
);

  localparam int unsigned CntW         = $clog2(cce_block_width_p / data_width_p) + 1;
  localparam int unsigned LgBeatBytes  = $clog2(data_width_p / 8);
  localparam int unsigned LgBlockBytes = $clog2(cce_block_width_p / 8);

  typedef enum logic [0:0] {e_ready, e_data} state_e;

  state_e              state_q;
  logic [gid_w_lp-1:0] rr_q, grant_q;
  logic [CntW-1:0]     cnt_q;

  logic [gid_w_lp-1:0] grant_sel, cur_gid, next_ptr;
  logic                any_v, hdr_fire, data_fire, has_data;
  logic [hdr_w_lp-1:0] hdr_sel;
  logic [3:0]          msg_type;
  logic [2:0]          msg_size;
  logic [CntW-1:0]     beats;

  // First valid header at or above rr_q, wrapping around.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx       = 0;
    found     = 1'b0;
    grant_sel = rr_q;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      idx = (32'(rr_q) + k) % num_req_p;
      if (!found && msg_header_v_i[idx]) begin
        grant_sel = gid_w_lp'(idx);
        found     = 1'b1;
      end
    end
  end

  assign any_v    = |msg_header_v_i;
  assign cur_gid  = (state_q == e_ready && any_v) ? grant_sel : grant_q;
  assign next_ptr = (cur_gid == gid_w_lp'(num_req_p - 1)) ? '0 : cur_gid + gid_w_lp'(1);

  assign hdr_sel  = msg_header_i[cur_gid*hdr_w_lp +: hdr_w_lp];
  assign msg_type = hdr_sel[3:0];
  assign msg_size = hdr_sel[8+paddr_width_p +: 3];
  assign has_data = payload_mask_p[msg_type];

  // Sub-beat sizes still occupy one full beat.
  always_comb begin
    beats = '0;
    if (has_data) begin
      if (32'(msg_size) <= LgBeatBytes) beats = CntW'(1);
      else                              beats = CntW'(1 << (32'(msg_size) - LgBeatBytes));
    end
  end

  always_comb begin
    msg_header_o           = hdr_sel;
    msg_data_o             = msg_data_i[cur_gid*data_width_p +: data_width_p];
    msg_header_v_o         = 1'b0;
    msg_data_v_o           = 1'b0;
    msg_header_ready_and_o = '0;
    msg_data_ready_and_o   = '0;
    grant_id_o             = reset_i ? '0 : cur_gid;
    if (!reset_i) begin
      if (state_q == e_ready) begin
        msg_header_v_o                  = any_v;
        msg_header_ready_and_o[cur_gid] = msg_header_ready_and_i;
      end else begin
        msg_data_v_o                  = msg_data_v_i[cur_gid];
        msg_data_ready_and_o[cur_gid] = msg_data_ready_and_i;
      end
    end
  end

  assign hdr_fire  = msg_header_v_o & msg_header_ready_and_i;
  assign data_fire = msg_data_v_o & msg_data_ready_and_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        e_ready: begin
          if (hdr_fire) begin
            grant_q <= grant_sel;
            if (beats == '0) begin
              rr_q <= next_ptr;
            end else begin
              cnt_q   <= beats - CntW'(1);
              state_q <= e_data;
            end
          end
        end
        e_data: begin
          if (data_fire) begin
            if (cnt_q == '0) begin
              state_q <= e_ready;
              rr_q    <= next_ptr;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
        end
        default: state_q <= e_ready;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && hdr_fire) begin
      assert (32'(msg_size) <= LgBlockBytes);
    end
  end

endmodule

// File: tb/tb_bp_burst_stream_arbiter.sv
// Directed bench for bp_burst_stream_arbiter: two requesters, 64-bit beats, write type 1 carries data.
module tb_bp_burst_stream_arbiter;

  localparam int unsigned PW = 32;
  localparam int unsigned PL = 8;
  localparam int unsigned HW = PL + 3 + PW + 8;
  localparam logic [3:0]  RD = 4'd0;
  localparam logic [3:0]  WR = 4'd1;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [2*HW-1:0] hdr_i;
  logic [1:0]      hdr_v_i;
  logic [1:0]      hdr_rdy_o;
  logic [127:0]    data_i;
  logic [1:0]      data_v_i;
  logic [1:0]      data_rdy_o;
  logic [HW-1:0]   hdr_o;
  logic            hdr_v_o;
  logic            hdr_rdy_i;
  logic [63:0]     data_o;
  logic            data_v_o;
  logic            data_rdy_i;
  logic [0:0]      gid_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  bp_burst_stream_arbiter #(
    .paddr_width_p    (PW),
    .cce_block_width_p(512),
    .data_width_p     (64),
    .payload_width_p  (PL),
    .num_req_p        (2),
    .payload_mask_p   (16'h0002)
  ) dut (
    .clk_i                 (clk),
    .reset_i               (reset_i),
    .msg_header_i          (hdr_i),
    .msg_header_v_i        (hdr_v_i),
    .msg_header_ready_and_o(hdr_rdy_o),
    .msg_data_i            (data_i),
    .msg_data_v_i          (data_v_i),
    .msg_data_ready_and_o  (data_rdy_o),
    .msg_header_o          (hdr_o),
    .msg_header_v_o        (hdr_v_o),
    .msg_header_ready_and_i(hdr_rdy_i),
    .msg_data_o            (data_o),
    .msg_data_v_o          (data_v_o),
    .msg_data_ready_and_i  (data_rdy_i),
    .grant_id_o            (gid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] sz,
                                           input logic [31:0] a);
    return {8'h5A, sz, a, 4'h0, t};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [HW-1:0] h0, ra, rb, w0, w1;
    logic [19:0]   bp_pat;
    int unsigned   b;

    // Reset with upstream valids high: everything must stay quiet.
    reset_i    = 1'b1;
    hdr_v_i    = 2'b11;
    data_v_i   = 2'b11;
    hdr_rdy_i  = 1'b1;
    data_rdy_i = 1'b1;
    hdr_i      = {mk_hdr(RD, 3'd0, 32'h1), mk_hdr(RD, 3'd0, 32'h0)};
    data_i     = '0;
    @(negedge clk); #1;
    chk("rst_hdr_rdy", hdr_rdy_o, 2'b00);
    chk("rst_data_rdy", data_rdy_o, 2'b00);
    chk("rst_hdr_v", hdr_v_o, 1'b0);
    chk("rst_data_v", data_v_o, 1'b0);
    chk("rst_gid", gid_o, 1'b0);
    @(negedge clk);
    reset_i  = 1'b0;
    hdr_v_i  = 2'b00;
    data_v_i = 2'b00;
    #1;
    chk("idle_hdr_v", hdr_v_o, 1'b0);
    chk("idle_gid", gid_o, 1'b0);

    // 64 B write from requester 0: header then 8 beats.
    @(negedge clk);
    h0            = mk_hdr(WR, 3'd6, 32'h1000);
    hdr_i[HW-1:0] = h0;
    hdr_v_i       = 2'b01;
    data_v_i      = 2'b01;
    data_i[63:0]  = 64'hA0;
    #1;
    chk("t1_hdr_v", hdr_v_o, 1'b1);
    chk("t1_hdr_o", hdr_o, h0);
    chk("t1_hdr_rdy", hdr_rdy_o, 2'b01);
    chk("t1_data_v_in_hdr", data_v_o, 1'b0);
    chk("t1_data_rdy_in_hdr", data_rdy_o, 2'b00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      hdr_v_i      = 2'b00;
      data_i[63:0] = 64'hA0 + 64'(i);
      #1;
      chk("t1_data_v", data_v_o, 1'b1);
      chk("t1_data_o", data_o, 64'hA0 + 64'(i));
      chk("t1_data_rdy", data_rdy_o, 2'b01);
      chk("t1_gid", gid_o, 1'b0);
      chk("t1_hdr_v_in_data", hdr_v_o, 1'b0);
    end

    // Both requesters with reads; rr_ptr is now 1 so requester 1 leads.
    @(negedge clk);
    data_v_i  = 2'b00;
    ra        = mk_hdr(RD, 3'd3, 32'h2000);
    rb        = mk_hdr(RD, 3'd3, 32'h2100);
    hdr_i     = {rb, ra};
    hdr_v_i   = 2'b11;
    hdr_rdy_i = 1'b0;
    #1;
    chk("t2_stall_hdr_rdy", hdr_rdy_o, 2'b00);
    chk("t2_stall_hdr_v", hdr_v_o, 1'b1);
    chk("t2_stall_gid", gid_o, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hdr_rdy_i = 1'b1;
      #1;
      chk("t2_gid", gid_o, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("t2_hdr_o", hdr_o, (k % 2 == 0) ? rb : ra);
      chk("t2_hdr_rdy", hdr_rdy_o, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("t2_data_v", data_v_o, 1'b0);
    end

    // 4-beat write from 0 with requester 1 header and data waiting throughout.
    @(negedge clk);
    w0       = mk_hdr(WR, 3'd5, 32'h3000);
    w1       = mk_hdr(WR, 3'd3, 32'h3100);
    hdr_i    = {w1, w0};
    hdr_v_i  = 2'b11;
    data_v_i = 2'b11;
    data_i   = {64'hBB, 64'hC0};
    #1;
    chk("t3_gid0", gid_o, 1'b0);
    chk("t3_hdr_o0", hdr_o, w0);
    chk("t3_hdr_rdy0", hdr_rdy_o, 2'b01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hdr_v_i      = 2'b10;
      data_i[63:0] = 64'hC0 + 64'(i);
      #1;
      chk("t3_data_o0", data_o, 64'hC0 + 64'(i));
      chk("t3_data_rdy0", data_rdy_o, 2'b01);
      chk("t3_hdr_v_locked", hdr_v_o, 1'b0);
      chk("t3_hdr_rdy_locked", hdr_rdy_o, 2'b00);
    end
    @(negedge clk);
    data_v_i = 2'b10;
    #1;
    chk("t3_gid1", gid_o, 1'b1);
    chk("t3_hdr_o1", hdr_o, w1);
    chk("t3_hdr_rdy1", hdr_rdy_o, 2'b10);
    chk("t3_data_rdy_hdr1", data_rdy_o, 2'b00);
    @(negedge clk);
    hdr_v_i = 2'b00;
    #1;
    chk("t3_data_v1", data_v_o, 1'b1);
    chk("t3_data_o1", data_o, 64'hBB);
    chk("t3_data_rdy1", data_rdy_o, 2'b10);

    // 1 B write still takes exactly one beat.
    @(negedge clk);
    data_v_i      = 2'b01;
    data_i[63:0]  = 64'hD1;
    hdr_i[HW-1:0] = mk_hdr(WR, 3'd0, 32'h4000);
    hdr_v_i       = 2'b01;
    #1;
    chk("t4_hdr_rdy", hdr_rdy_o, 2'b01);
    chk("t4_gid", gid_o, 1'b0);
    @(negedge clk);
    hdr_v_i = 2'b00;
    #1;
    chk("t4_data_o", data_o, 64'hD1);
    chk("t4_data_rdy", data_rdy_o, 2'b01);
    @(negedge clk); #1;
    chk("t4_after_data_v", data_v_o, 1'b0);
    chk("t4_after_data_rdy", data_rdy_o, 2'b00);

    // 8-beat write from requester 1 under client back-pressure.
    @(negedge clk);
    data_v_i          = 2'b00;
    hdr_i[2*HW-1:HW]  = mk_hdr(WR, 3'd6, 32'h5000);
    hdr_v_i           = 2'b10;
    #1;
    chk("t5_hdr_rdy", hdr_rdy_o, 2'b10);
    chk("t5_gid", gid_o, 1'b1);
    bp_pat = 20'b1011_0010_1101_0011_0101;
    b      = 0;
    for (int c = 0; c < 20 && b < 8; c++) begin
      @(negedge clk);
      hdr_v_i         = 2'b00;
      data_v_i        = 2'b10;
      data_rdy_i      = bp_pat[c];
      data_i[127:64]  = 64'hE0 + 64'(b);
      #1;
      chk("t5_data_o", data_o, 64'hE0 + 64'(b));
      chk("t5_data_v", data_v_o, 1'b1);
      chk("t5_data_rdy", data_rdy_o, {bp_pat[c], 1'b0});
      if (bp_pat[c]) b++;
    end
    chk("t5_beat_count", 64'(b), 64'd8);
    @(negedge clk);
    data_rdy_i = 1'b1;
    #1;
    chk("t5_done_data_v", data_v_o, 1'b0);

    // Reset after three of eight beats.
    @(negedge clk);
    data_v_i      = 2'b01;
    hdr_i[HW-1:0] = mk_hdr(WR, 3'd6, 32'h6000);
    hdr_v_i       = 2'b01;
    #1;
    chk("t6_hdr_rdy", hdr_rdy_o, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hdr_v_i      = 2'b00;
      data_i[63:0] = 64'hF0 + 64'(i);
      #1;
      chk("t6_data_o", data_o, 64'hF0 + 64'(i));
    end
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("t6_rst_data_v", data_v_o, 1'b0);
    chk("t6_rst_data_rdy", data_rdy_o, 2'b00);
    chk("t6_rst_hdr_v", hdr_v_o, 1'b0);
    @(negedge clk);
    reset_i  = 1'b0;
    data_v_i = 2'b00;
    hdr_i    = {mk_hdr(RD, 3'd0, 32'h7100), mk_hdr(RD, 3'd0, 32'h7000)};
    hdr_v_i  = 2'b11;
    #1;
    chk("t6_post_gid", gid_o, 1'b0);
    chk("t6_post_hdr_rdy", hdr_rdy_o, 2'b01);
    chk("t6_post_data_v", data_v_o, 1'b0);
    @(negedge clk);
    hdr_i[2*HW-1:HW] = mk_hdr(WR, 3'd3, 32'h7200);
    hdr_v_i          = 2'b10;
    data_v_i         = 2'b10;
    data_i[127:64]   = 64'hF1;
    #1;
    chk("t6_r1_gid", gid_o, 1'b1);
    chk("t6_r1_hdr_rdy", hdr_rdy_o, 2'b10);
    @(negedge clk);
    hdr_v_i = 2'b00;
    #1;
    chk("t6_r1_data_o", data_o, 64'hF1);
    chk("t6_r1_data_rdy", data_rdy_o, 2'b10);
    @(negedge clk);
    data_v_i = 2'b00;
    #1;
    chk("t6_end_data_v", data_v_o, 1'b0);
    chk("t6_end_gid", gid_o, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_burst_stream_arbiter.md
# bp_burst_stream_arbiter

Arbitrates between `num_req_p` BedRock burst streams (header channel plus data channel), such as the outputs of several lite-to-burst converters, onto a single burst stream toward one memory or I/O client. Grants are round-robin and apply per message. A grant stays locked from header acceptance until the last data beat of that message is sent, so header and data of different requesters never interleave. The block sits between the per-requester burst converters and the shared client port.

## Interface
- bp_params_p, e_bp_default_cfg, processor parameter set; supplies paddr_width_p, lce_id_width_p, lce_assoc_p, cce_block_width_p
- data_width_p, 64, burst data beat width; must be a power of two, ≥ 64 and ≤ cce_block_width_p
- payload_width_p, none, BedRock header payload width
- num_req_p, 2, number of requesters; must be ≥ 2
- payload_mask_p, 0, bitmask over msg_type; bit set = that message type carries data beats
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- msg_header_i  in  num_req_p*hdr_w  BedRock msg headers, requester i at slice i
- msg_header_v_i  in  num_req_p  header valid per requester
- msg_header_ready_and_o  out  num_req_p  header ready per requester
- msg_data_i  in  num_req_p*data_width_p  data beats, requester i at slice i
- msg_data_v_i  in  num_req_p  data valid per requester
- msg_data_ready_and_o  out  num_req_p  data ready per requester
- msg_header_o  out  hdr_w  arbitrated header
- msg_header_v_o  out  1  header valid
- msg_header_ready_and_i  in  1  client header ready
- msg_data_o  out  data_width_p  arbitrated data beat
- msg_data_v_o  out  1  data valid
- msg_data_ready_and_i  in  1  client data ready
- grant_id_o  out  clog2(num_req_p)  current or last granted requester, used to route responses

## Operation
- Both channels use ready-valid-and handshakes. A transfer occurs when valid and ready are high in the same cycle.
- Beat count of a header: beats = has_data ? max(1, (1<<size)/(data_width_p/8)) : 0, where has_data = payload_mask_p[msg_type]. The beat counter is clog2(cce_block_width_p/data_width_p)+1 bits wide. Sizes above cce_block_width_p are illegal; an assertion fires on them.
- rr_ptr (clog2(num_req_p) bits) is the highest-priority requester. The search goes upward from rr_ptr and wraps.
- e_ready state:
  - grant = first i at or after rr_ptr with msg_header_v_i[i].
  - msg_header_o = header[grant]; msg_header_v_o = |msg_header_v_i.
  - msg_header_ready_and_o[grant] = msg_header_ready_and_i; all other header readies are 0.
  - All data readies are 0 and msg_data_v_o = 0.
  - On header handshake with beats = 0: stay in e_ready; rr_ptr ← grant+1 mod num_req_p.
  - On header handshake with beats > 0: latch grant, cnt ← beats-1, go to e_data.
- e_data state:
  - msg_data_o = data[grant]; msg_data_v_o = msg_data_v_i[grant].
  - msg_data_ready_and_o[grant] = msg_data_ready_and_i; all other data readies are 0.
  - All header readies are 0 and msg_header_v_o = 0.
  - On each data handshake: if cnt = 0, go to e_ready and set rr_ptr ← grant+1 mod num_req_p; otherwise cnt ← cnt-1.
- grant_id_o: in e_ready it shows the combinational winner when any header is valid, otherwise the latched value. In e_data it shows the latched grant.
- Non-granted requesters' data is never consumed, so data valid before its header is legal and is simply held.

## Timing
- Reset values:
  - state = e_ready, rr_ptr = 0, cnt = 0, grant_id_o = 0.
  - msg_header_v_o = msg_data_v_o = 0.
  - All ready outputs = 0 while reset_i is high.
- Header and data paths are combinational pass-through with zero latency. There are valid→ready and valid→valid paths; there is no ready_i→valid_o path.
- The data phase starts the cycle after header acceptance. The minimum message time is 1 + beats cycles.
- A new header can be accepted in the cycle after the last beat. Header-only messages sustain 1 per cycle.
- Simultaneous valid headers: the winner is nearest at or above rr_ptr. Losers hold their valid with no handshake, and the loser wins the next arbitration.
- Reset asserted mid-burst: the block returns to e_ready next cycle and drops the remaining beats. Upstream must be reset together with this block.
- Client back-pressure in e_data: cnt and grant hold and no upstream data is consumed.

## Test plan
- Single requester 0, header with write type in payload_mask_p, size 64 B, data_width_p = 64 -> one header out, then exactly 8 beats in order from requester 0; grant_id_o = 0; rr_ptr becomes 1.
- Requesters 0 and 1 both valid with read headers (no data) every cycle -> headers out alternating 0,1,0,1 on consecutive cycles; no data valid.
- Requester 0 sends a 4-beat write; requester 1 header plus data valid throughout -> all 4 beats of requester 0 complete before requester 1's header is accepted; requester 1 data ready stays 0 until its own e_data.
- Size 8 B write with data_width_p = 64 -> header plus exactly 1 beat; size 1 B also gives 1 beat.
- Random client back-pressure on msg_data_ready_and_i during an 8-beat burst -> beat order and count preserved; no beat duplicated or dropped.
- reset_i pulsed after beat 3 of 8 -> next cycle all valid outputs are 0, state is e_ready, rr_ptr = 0; a fresh header from requester 1 is then accepted normally.
